// File: rtl/adder_checker_if.sv
// adder_checker_if
// Bundle of the signals a checker observes around one adder lane: the
// operands as they are applied to the adder and the adder's registered
// result one cycle later.
//   vld       - operands on x/y/cin are applied to the adder this cycle
//   x, y, cin - operands, identical to what the adder sees
//   sm_r      - adder's registered sum (WIDTH+1 bits)
//   sm_zero_r - adder's registered zero flag
// master: the side that drives these (adder wrapper / testbench)
// slave:  the checker
interface adder_checker_if #(
  parameter int WIDTH  = 8,
  parameter int SWIDTH = WIDTH + 1
);
  logic              vld;
  logic [WIDTH-1:0]  x;
  logic [WIDTH-1:0]  y;
  logic              cin;
  logic [SWIDTH-1:0] sm_r;
  logic              sm_zero_r;

  modport master (output vld, x, y, cin, sm_r, sm_zero_r);
  modport slave  (input  vld, x, y, cin, sm_r, sm_zero_r);
endinterface

// File: rtl/adder_checker.sv
// adder_checker
// Confirms one adder lane by subtracting the delayed operands back out of
// the registered sum and checking the zero flag. Counts checks and errors
// and latches into FAIL after ERR_LIMIT errors.
// Ports:
//   clk, rst        - clock, async active-high reset
//   bus (slave)     - operands and registered adder result
//   en              - level-sensitive checking enable
//   clr             - one-cycle clear of counters and status
//   busy, fail      - state is RUN / FAIL
//   err_pulse       - one-cycle pulse per detected mismatch
//   chk_cnt/err_cnt - saturating check / mismatch counters
//
// state | meaning
// IDLE  | disabled, no comparisons
// RUN   | capturing operands and comparing results
// FAIL  | error limit reached; counters frozen until clr or rst
module adder_checker #(
  parameter int WIDTH     = 8,
  parameter int SWIDTH    = WIDTH + 1,
  parameter int CNTW      = 16,
  parameter int ERR_LIMIT = 1
) (
  input  logic            clk,
  input  logic            rst,
  adder_checker_if.slave  bus,
  input  logic            en,
  input  logic            clr,
  output logic            busy,
  output logic            fail,
  output logic            err_pulse,
  output logic [CNTW-1:0] chk_cnt,
  output logic [CNTW-1:0] err_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam logic [CNTW-1:0] LIMIT   = CNTW'(ERR_LIMIT);

  state_t            state;
  state_t            state_nxt;
  logic              vld_d;
  logic [WIDTH-1:0]  x_d;
  logic [WIDTH-1:0]  y_d;
  logic              cin_d;
  logic [SWIDTH-1:0] diff;
  logic              mismatch;
  logic              cmp_fire;
  logic              err_fire;
  logic              limit_hit;
  logic [CNTW-1:0]   chk_inc;
  logic [CNTW-1:0]   err_inc;

  // Modular subtraction: a correct adder leaves exactly zero behind.
  assign diff     = bus.sm_r - SWIDTH'(x_d) - SWIDTH'(y_d) - SWIDTH'(cin_d);
  assign mismatch = (diff != '0) || (bus.sm_zero_r != (bus.sm_r == '0));

  // en low drops the pending comparison; clr discards it.
  assign cmp_fire  = (state == ST_RUN) && vld_d && en && !clr;
  assign err_fire  = cmp_fire && mismatch;

  assign chk_inc   = (chk_cnt == CNT_MAX) ? chk_cnt : chk_cnt + CNTW'(1);
  assign err_inc   = (err_cnt == CNT_MAX) ? err_cnt : err_cnt + CNTW'(1);
  assign limit_hit = err_fire && (err_inc >= LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = en ? ST_RUN : ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (en) state_nxt = ST_RUN;
        ST_RUN: begin
          if (!en)           state_nxt = ST_IDLE;
          else if (limit_hit) state_nxt = ST_FAIL;
        end
        ST_FAIL: state_nxt = ST_FAIL;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == ST_RUN);
    fail = (state == ST_FAIL);
  end

  // Alignment stage: lines the operands up with the adder's registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_d <= 1'b0;
      x_d   <= '0;
      y_d   <= '0;
      cin_d <= 1'b0;
    end else begin
      vld_d <= !clr && (state == ST_RUN) && bus.vld;
      if (!clr && (state == ST_RUN) && bus.vld) begin
        x_d   <= bus.x;
        y_d   <= bus.y;
        cin_d <= bus.cin;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_cnt   <= '0;
      err_cnt   <= '0;
      err_pulse <= 1'b0;
    end else if (clr) begin
      chk_cnt   <= '0;
      err_cnt   <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= err_fire;
      if (cmp_fire) chk_cnt <= chk_inc;
      if (err_fire) err_cnt <= err_inc;
    end
  end

endmodule

// File: tb/tb_adder_checker.sv
// tb_adder_checker
// Drives one operand/result stream into two checkers (ERR_LIMIT 1 and 3)
// and compares every output each cycle with a behavioural model, plus
// directed checks with hand-derived constants.
module tb_adder_checker;
  localparam int WIDTH  = 8;
  localparam int SWIDTH = 9;
  localparam int CNTW   = 16;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic clr;
  logic busy_1, fail_1, err_pulse_1;
  logic busy_3, fail_3, err_pulse_3;
  logic [CNTW-1:0] chk_cnt_1, err_cnt_1, chk_cnt_3, err_cnt_3;

  adder_checker_if #(.WIDTH(WIDTH), .SWIDTH(SWIDTH)) bus ();

  adder_checker #(.WIDTH(WIDTH), .SWIDTH(SWIDTH), .CNTW(CNTW), .ERR_LIMIT(1)) dut_1 (
    .clk(clk), .rst(rst), .bus(bus), .en(en), .clr(clr),
    .busy(busy_1), .fail(fail_1), .err_pulse(err_pulse_1),
    .chk_cnt(chk_cnt_1), .err_cnt(err_cnt_1));

  adder_checker #(.WIDTH(WIDTH), .SWIDTH(SWIDTH), .CNTW(CNTW), .ERR_LIMIT(3)) dut_3 (
    .clk(clk), .rst(rst), .bus(bus), .en(en), .clr(clr),
    .busy(busy_3), .fail(fail_3), .err_pulse(err_pulse_3),
    .chk_cnt(chk_cnt_3), .err_cnt(err_cnt_3));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model, one entry per checker instance.
  int lim [2] = '{1, 3};
  bit m_run [2], m_fail [2], m_pulse [2], m_pend [2];
  int m_chk [2], m_err [2], m_px [2], m_py [2], m_pc [2];

  // Adder result scheduled for the next cycle.
  int nxt_sm = 0;
  bit nxt_z  = 1'b1;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_fail[k] = 0; m_pulse[k] = 0; m_pend[k] = 0;
      m_chk[k] = 0; m_err[k] = 0;
    end
  endfunction

  // Advance the model by one rising edge using the inputs currently driven.
  function automatic void model_step(int k);
    bit run = m_run[k];
    bit was_fail = m_fail[k];
    bit do_cmp, bad;
    int sum_exp;
    sum_exp = (m_px[k] + m_py[k] + m_pc[k]) % 512;
    do_cmp  = run && m_pend[k] && (en == 1'b1) && (clr == 1'b0);
    bad     = do_cmp && ((int'(bus.sm_r) != sum_exp) ||
                         (bus.sm_zero_r != (bus.sm_r == 0)));
    m_pend[k] = run && (bus.vld == 1'b1) && (clr == 1'b0);
    if (m_pend[k]) begin
      m_px[k] = int'(bus.x);
      m_py[k] = int'(bus.y);
      m_pc[k] = int'(bus.cin);
    end
    if (clr) begin
      m_chk[k] = 0; m_err[k] = 0; m_pulse[k] = 0; m_fail[k] = 0;
      m_run[k] = en;
    end else begin
      m_pulse[k] = bad;
      if (do_cmp && m_chk[k] < 65535) m_chk[k]++;
      if (bad && m_err[k] < 65535) m_err[k]++;
      if (!was_fail) begin
        if (run) begin
          if (!en) m_run[k] = 0;
          else if (bad && m_err[k] >= lim[k]) begin
            m_run[k] = 0;
            m_fail[k] = 1;
          end
        end else begin
          m_run[k] = en;
        end
      end
    end
  endfunction

  task automatic check_dut(input int k, input logic b, input logic f, input logic p,
                           input logic [CNTW-1:0] c, input logic [CNTW-1:0] e);
    check_eq($sformatf("busy_l%0d", lim[k]),      int'(b), int'(m_run[k]));
    check_eq($sformatf("fail_l%0d", lim[k]),      int'(f), int'(m_fail[k]));
    check_eq($sformatf("err_pulse_l%0d", lim[k]), int'(p), int'(m_pulse[k]));
    check_eq($sformatf("chk_cnt_l%0d", lim[k]),   int'(c), m_chk[k]);
    check_eq($sformatf("err_cnt_l%0d", lim[k]),   int'(e), m_err[k]);
  endtask

  task automatic check_all();
    check_dut(0, busy_1, fail_1, err_pulse_1, chk_cnt_1, err_cnt_1);
    check_dut(1, busy_3, fail_3, err_pulse_3, chk_cnt_3, err_cnt_3);
  endtask

  // One cycle: present last cycle's adder result plus new operands/controls.
  // corrupt: 0 none, 1 sum off by one, 2 zero flag inverted.
  task automatic cyc(input bit e, input bit c, input bit v,
                     input int xx, input int yy, input int cc, input int corrupt);
    int s;
    bus.sm_r      = 9'(nxt_sm);
    bus.sm_zero_r = nxt_z;
    en      = e;
    clr     = c;
    bus.vld = v;
    bus.x   = 8'(xx);
    bus.y   = 8'(yy);
    bus.cin = cc[0];
    s = xx + yy + cc;
    if (corrupt == 1) s = s - 1;
    nxt_sm = s & 511;
    nxt_z  = (nxt_sm == 0) ^ (corrupt == 2);
    model_step(0);
    model_step(1);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0;
    bus.vld = 1'b0; bus.x = '0; bus.y = '0; bus.cin = 1'b0;
    bus.sm_r = '0; bus.sm_zero_r = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_all();
    check_eq("rst_busy", int'(busy_1), 0);
    check_eq("rst_chk",  int'(chk_cnt_3), 0);

    // Normal add with carry-out
    idle(1);
    cyc(1, 0, 1, 200, 100, 1, 0);
    idle(1);
    check_eq("add_chk",   int'(chk_cnt_1), 1);
    check_eq("add_err",   int'(err_cnt_1), 0);
    check_eq("add_pulse", int'(err_pulse_1), 0);

    // Corrupted sum (300 instead of 301)
    cyc(1, 0, 1, 200, 100, 1, 1);
    idle(1);
    check_eq("bad_pulse",  int'(err_pulse_1), 1);
    check_eq("bad_fail1",  int'(fail_1), 1);
    check_eq("bad_busy1",  int'(busy_1), 0);
    check_eq("bad_err3",   int'(err_cnt_3), 1);
    check_eq("bad_busy3",  int'(busy_3), 1);
    idle(1);
    check_eq("bad_pulse_end", int'(err_pulse_3), 0);

    // Zero flag forced wrong on 0+0+0
    cyc(1, 1, 0, 0, 0, 0, 0);
    check_eq("clr_busy1", int'(busy_1), 1);
    cyc(1, 0, 1, 0, 0, 0, 2);
    idle(1);
    check_eq("zero_err1", int'(err_cnt_1), 1);
    check_eq("zero_err3", int'(err_cnt_3), 1);

    // Full-width wrap passes
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 255, 255, 1, 0);
    idle(1);
    check_eq("wrap_chk", int'(chk_cnt_1), 1);
    check_eq("wrap_err", int'(err_cnt_1), 0);

    // Error limit 3: errors on vectors 2, 5, 7 of 10 back-to-back
    cyc(1, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      cyc(1, 0, 1, 17 * i, 9 * i, i & 1, (i == 2 || i == 5 || i == 7) ? 1 : 0);
      if (i == 7) check_eq("lim_fail_early", int'(fail_3), 0);
      if (i == 8) begin
        check_eq("lim_fail", int'(fail_3), 1);
        check_eq("lim_err",  int'(err_cnt_3), 3);
        check_eq("lim_chk",  int'(chk_cnt_3), 7);
      end
    end
    idle(2);
    check_eq("frz_err", int'(err_cnt_3), 3);
    check_eq("frz_chk", int'(chk_cnt_3), 7);

    // clr colliding with a mismatching comparison
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 200, 100, 1, 1);
    cyc(1, 1, 0, 0, 0, 0, 0);
    check_eq("coll_chk",   int'(chk_cnt_3), 0);
    check_eq("coll_err",   int'(err_cnt_3), 0);
    check_eq("coll_pulse", int'(err_pulse_3), 0);
    check_eq("coll_busy",  int'(busy_3), 1);
    idle(1);
    check_eq("coll_pulse2", int'(err_pulse_3), 0);

    // Reset between t and t+1 of a vector
    cyc(1, 0, 1, 40, 50, 0, 0);
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("mrst_busy", int'(busy_3), 0);
    check_eq("mrst_chk",  int'(chk_cnt_3), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 40, 50, 1, 0);
    idle(1);
    check_eq("mrst_chk_after", int'(chk_cnt_3), 1);
    check_eq("mrst_err_after", int'(err_cnt_1), 0);

    // Randomised traffic against the model
    for (int i = 0; i < 800; i++) begin
      cyc($urandom_range(0, 15) != 0, $urandom_range(0, 40) == 0,
          $urandom_range(0, 3) != 0,
          int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
          int'($urandom_range(0, 1)),
          ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
